// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared phase/direction codes, timing defaults and lamp decode for the traffic-light scheduler
package tlc_pkg;

    typedef enum logic [2:0] {
        ST_NS_G = 3'd0,
        ST_NS_Y = 3'd1,
        ST_AR   = 3'd2,
        ST_EW_G = 3'd3,
        ST_EW_Y = 3'd4,
        ST_PED  = 3'd5
    } phase_t;

    typedef enum logic [1:0] {
        DIR_NS  = 2'd0,
        DIR_EW  = 2'd1,
        DIR_PED = 2'd2
    } dir_t;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
        logic walk;
    } lamps_t;

    localparam int DEF_GREEN_MIN = 10;
    localparam int DEF_GREEN_MAX = 40;
    localparam int DEF_YELLOW_T  = 4;
    localparam int DEF_ALLRED_T  = 2;
    localparam int DEF_WALK_T    = 15;

    localparam logic [5:0] CNT_SAT = 6'd63;

    // Moore lamp pattern for each phase; unknown codes show all-red.
    function automatic lamps_t decode_lamps(input phase_t ph);
        lamps_t l;
        l = '{ns_red: 1'b1, ns_yellow: 1'b0, ns_green: 1'b0,
              ew_red: 1'b1, ew_yellow: 1'b0, ew_green: 1'b0, walk: 1'b0};
        case (ph)
            ST_NS_G: begin l.ns_red = 1'b0; l.ns_green  = 1'b1; end
            ST_NS_Y: begin l.ns_red = 1'b0; l.ns_yellow = 1'b1; end
            ST_EW_G: begin l.ew_red = 1'b0; l.ew_green  = 1'b1; end
            ST_EW_Y: begin l.ew_red = 1'b0; l.ew_yellow = 1'b1; end
            ST_PED:  l.walk = 1'b1;
            default: ;
        endcase
        return l;
    endfunction

    // Round-robin NS -> EW -> PED starting after the last served direction; NS when idle.
    function automatic dir_t rr_pick(input dir_t last, input logic ns, input logic ew, input logic ped);
        dir_t d;
        d = DIR_NS;
        case (last)
            DIR_NS:  d = ew ? DIR_EW : (ped ? DIR_PED : DIR_NS);
            DIR_EW:  d = ped ? DIR_PED : (ns ? DIR_NS : (ew ? DIR_EW : DIR_NS));
            default: d = ns ? DIR_NS : (ew ? DIR_EW : (ped ? DIR_PED : DIR_NS));
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// rtl/tlc_phase_timer.sv - tick-enabled phase counter with clear and saturation at 63
module tlc_phase_timer
    import tlc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       tick,
    output logic [5:0] count
);

    // Clear wins so the count reads 0 in the first cycle of a new phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != CNT_SAT)) begin
            count <= count + 6'd1;
        end
    end

endmodule

// File: rtl/tlc_phase_sched.sv
// rtl/tlc_phase_sched.sv - two-way intersection phase scheduler with pedestrian phase
module tlc_phase_sched
    import tlc_pkg::*;
#(
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_NS_vd,
    input  logic       i_EW_vd,
    input  logic       i_ped_req,
    output logic       o_NS_red,
    output logic       o_NS_yellow,
    output logic       o_NS_green,
    output logic       o_EW_red,
    output logic       o_EW_yellow,
    output logic       o_EW_green,
    output logic       o_walk,
    output logic [2:0] o_phase,
    output logic [5:0] o_count
);

    localparam logic [5:0] GMIN_LAST = 6'(GREEN_MIN - 1);
    localparam logic [5:0] GMAX_LAST = 6'(GREEN_MAX - 1);
    localparam logic [5:0] YEL_LAST  = 6'(YELLOW_T - 1);
    localparam logic [5:0] AR_LAST   = 6'(ALLRED_T - 1);
    localparam logic [5:0] WALK_LAST = 6'(WALK_T - 1);

    phase_t     state;
    phase_t     nxt;
    logic       go;
    dir_t       last_served;
    dir_t       pick;
    logic       ns_pend;
    logic       ew_pend;
    logic       ped_pend;
    lamps_t     lamps;
    logic [5:0] count;

    tlc_phase_timer u_timer (
        .clk   (i_clk),
        .rst   (i_rst),
        .clear (go),
        .tick  (i_tick),
        .count (count)
    );

    // Next-phase selection; every exit is gated by the tick so idle cycles never move the FSM.
    always_comb begin
        go   = 1'b0;
        nxt  = state;
        pick = rr_pick(last_served, ns_pend, ew_pend, ped_pend);
        case (state)
            ST_NS_G: if (i_tick && (count >= GMIN_LAST) && (ew_pend || ped_pend) &&
                         (!i_NS_vd || (count >= GMAX_LAST))) begin
                go  = 1'b1;
                nxt = ST_NS_Y;
            end
            ST_EW_G: if (i_tick && (count >= GMIN_LAST) && (ns_pend || ped_pend) &&
                         (!i_EW_vd || (count >= GMAX_LAST))) begin
                go  = 1'b1;
                nxt = ST_EW_Y;
            end
            ST_NS_Y, ST_EW_Y: if (i_tick && (count == YEL_LAST)) begin
                go  = 1'b1;
                nxt = ST_AR;
            end
            ST_PED: if (i_tick && (count == WALK_LAST)) begin
                go  = 1'b1;
                nxt = ST_AR;
            end
            ST_AR: if (i_tick && (count == AR_LAST)) begin
                go  = 1'b1;
                nxt = (pick == DIR_EW) ? ST_EW_G : ((pick == DIR_PED) ? ST_PED : ST_NS_G);
            end
            default: begin
                go  = 1'b1;
                nxt = ST_AR;
            end
        endcase
    end

    // Phase register, registered lamp decode, request latches and round-robin pointer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_AR;
            lamps       <= decode_lamps(ST_AR);
            last_served <= DIR_PED;
            ns_pend     <= 1'b0;
            ew_pend     <= 1'b0;
            ped_pend    <= 1'b0;
        end else begin
            if (go) begin
                state <= nxt;
                lamps <= decode_lamps(nxt);
                if (nxt == ST_NS_G) last_served <= DIR_NS;
                if (nxt == ST_EW_G) last_served <= DIR_EW;
                if (nxt == ST_PED)  last_served <= DIR_PED;
            end
            ns_pend  <= (go && (nxt == ST_NS_G)) ? 1'b0 : (ns_pend  | (i_NS_vd   && (state != ST_NS_G)));
            ew_pend  <= (go && (nxt == ST_EW_G)) ? 1'b0 : (ew_pend  | (i_EW_vd   && (state != ST_EW_G)));
            ped_pend <= (go && (nxt == ST_PED))  ? 1'b0 : (ped_pend | (i_ped_req && (state != ST_PED)));
        end
    end

    assign o_NS_red    = lamps.ns_red;
    assign o_NS_yellow = lamps.ns_yellow;
    assign o_NS_green  = lamps.ns_green;
    assign o_EW_red    = lamps.ew_red;
    assign o_EW_yellow = lamps.ew_yellow;
    assign o_EW_green  = lamps.ew_green;
    assign o_walk      = lamps.walk;
    assign o_phase     = state;
    assign o_count     = count;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// tb/tb_tlc_phase_sched.sv - directed self-checking bench for tlc_phase_sched
module tb_tlc_phase_sched;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       ns_vd;
    logic       ew_vd;
    logic       ped_req;
    logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk;
    logic [2:0] phase;
    logic [5:0] count;
    logic [6:0] lamp_vec;

    int errors = 0;
    int checks = 0;
    int n;
    int cyc = 0;
    logic tick_slow = 1'b0;

    assign lamp_vec = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk};

    tlc_phase_sched dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tick      (tick),
        .i_NS_vd     (ns_vd),
        .i_EW_vd     (ew_vd),
        .i_ped_req   (ped_req),
        .o_NS_red    (ns_r),
        .o_NS_yellow (ns_y),
        .o_NS_green  (ns_g),
        .o_EW_red    (ew_r),
        .o_EW_yellow (ew_y),
        .o_EW_green  (ew_g),
        .o_walk      (walk),
        .o_phase     (phase),
        .o_count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick generator: every cycle, or every 4th cycle when tick_slow is set.
    initial begin
        tick = 1'b1;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            tick = (tick_slow && ((cyc % 4) != 0)) ? 1'b0 : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] exp_lamps(input int p);
        case (p)
            0:       return 7'b0011000;
            1:       return 7'b0101000;
            3:       return 7'b1000010;
            4:       return 7'b1000100;
            5:       return 7'b1001001;
            default: return 7'b1001000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int p);
        chk({tag, "_phase"}, 32'(phase), p);
        chk({tag, "_lamps"}, 32'(lamp_vec), 32'(exp_lamps(p)));
    endtask

    task automatic run_len(input int p, output int len);
        len = 0;
        while ((phase == 3'(p)) && (len < 300)) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_phase(input string tag, input int p, input int maxc);
        int k;
        k = 0;
        while ((phase != 3'(p)) && (k < maxc)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(phase), p);
    endtask

    initial begin
        rst = 1'b1; ns_vd = 1'b0; ew_vd = 1'b0; ped_req = 1'b0;
        #1;
        chk_state("reset", 2);
        chk("reset_count", 32'(count), 0);

        // Release reset: AR for two ticks, then rest in NS green.
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_state("ar_after_reset", 2);
        chk("ar_count1", 32'(count), 1);
        @(negedge clk);
        chk_state("ns_g_first", 0);
        chk("ns_g_entry_count", 32'(count), 0);
        repeat (70) @(negedge clk);
        chk_state("ns_g_rest", 0);
        chk("ns_g_saturate", 32'(count), 63);

        // EW request against a long-resting NS green.
        ew_vd = 1'b1; @(negedge clk); ew_vd = 1'b0;
        chk("ns_g_latch_cycle", 32'(phase), 0);
        @(negedge clk);
        chk_state("ns_y_entry", 1);
        chk("ns_y_entry_count", 32'(count), 0);
        run_len(1, n); chk("ns_y_len", n, 4);
        chk_state("ar1", 2);
        run_len(2, n); chk("ar1_len", n, 2);
        chk_state("ew_g_entry", 3);

        // Pedestrian and NS together from EW green: PED served first.
        ped_req = 1'b1; ns_vd = 1'b1; @(negedge clk); ped_req = 1'b0; ns_vd = 1'b0;
        run_len(3, n); chk("ew_g_min_len", n, 9);
        chk_state("ew_y_entry", 4);
        run_len(4, n); chk("ew_y_len", n, 4);
        run_len(2, n); chk("ar2_len", n, 2);
        chk_state("ped_entry", 5);
        run_len(5, n); chk("ped_len", n, 15);
        chk_state("ar3", 2);
        run_len(2, n); chk("ar3_len", n, 2);
        chk_state("ns_after_ped", 0);

        // EW pulse at count 3: minimum green still applies.
        repeat (3) @(negedge clk);
        chk("ns_g_count3", 32'(count), 3);
        ew_vd = 1'b1; @(negedge clk); ew_vd = 1'b0;
        run_len(0, n); chk("ns_g_min_rest", n, 6);
        chk_state("ns_y_entry2", 1);
        run_len(1, n); chk("ns_y_len2", n, 4);
        run_len(2, n); chk("ar4_len", n, 2);
        chk_state("ew_g_entry2", 3);
        chk("ew_g_entry2_count", 32'(count), 0);

        // Return to NS, then hold NS detect to force the maximum green.
        ns_vd = 1'b1; @(negedge clk); ns_vd = 1'b0;
        run_len(3, n); chk("ew_g_min_len2", n, 9);
        run_len(4, n); chk("ew_y_len2", n, 4);
        run_len(2, n); chk("ar5_len", n, 2);
        chk_state("ns_g_entry3", 0);
        ns_vd = 1'b1; ew_vd = 1'b1; @(negedge clk); ew_vd = 1'b0;
        run_len(0, n); chk("ns_g_max_len", n, 39);
        chk_state("ns_y_after_max", 1);
        ns_vd = 1'b0;
        run_len(1, n); chk("ns_y_len3", n, 4);
        run_len(2, n); chk("ar6_len", n, 2);
        chk_state("ew_g_entry3", 3);

        // Slow timebase: tick every 4th cycle, request on a non-tick cycle.
        repeat (12) @(negedge clk);
        chk_state("ew_g_rest", 3);
        tick_slow = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        for (int k = 0; (k < 8) && tick; k++) begin
            @(negedge clk);
            #1;
        end
        chk("non_tick_found", 32'(tick), 0);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("no_move_non_tick", 32'(phase), 3);
        wait_phase("slow_ew_y_reached", 4, 10);
        run_len(4, n); chk("slow_ew_y_len", n, 16);
        run_len(2, n); chk("slow_ar_len", n, 8);
        chk_state("slow_ped_entry", 5);
        run_len(5, n); chk("slow_ped_len", n, 60);
        run_len(2, n); chk("slow_ar2_len", n, 8);
        chk_state("slow_ns_g", 0);
        tick_slow = 1'b0;

        // Asynchronous reset mid-yellow with EW pending: EW is not served.
        repeat (12) @(negedge clk);
        ew_vd = 1'b1; @(negedge clk); ew_vd = 1'b0;
        @(negedge clk);
        chk_state("pre_rst_ns_y", 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_state("rst_mid", 2);
        chk("rst_mid_count", 32'(count), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_state("rst_ar", 2);
        @(negedge clk);
        chk_state("rst_ns_g", 0);
        repeat (20) @(negedge clk);
        chk_state("rst_ew_dropped", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
